// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port between N byte-stream requesters, a whole message at a time, round-robin.
// Latency: a request is granted one edge after it is seen, and granted bytes reach the FIFO combinationally. One idle cycle separates messages.
// Backpressure: fifoFull clears reqReady/fifoWrEn and holds the grant. Non-granted requesters always see reqReady = 0.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   reqValid/reqData/reqLast/reqReady   per-requester byte stream (reqData is N x 8 bits flattened)
//   grant            one-hot current owner, zero when idle
//   fifoWrEn/fifoDin/fifoFull           UART TX FIFO write side
//   busy             a message is in progress
//   abortCount       saturating count of timeout releases
//
// Option macro UART_TX_ARB_TIMEOUT_EN: when it is defined, the grant is force-released after TIMEOUT
// cycles in which the owner has no byte and the FIFO is not full. When it is undefined,
// abortCount is tied to zero and the grant is held until reqLast.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   reqValid,
  input  logic [8*N-1:0] reqData,
  input  logic [N-1:0]   reqLast,
  output logic [N-1:0]   reqReady,
  output logic [N-1:0]   grant,
  output logic           fifoWrEn,
  output logic [7:0]     fifoDin,
  input  logic           fifoFull,
  output logic           busy,
  output logic [7:0]     abortCount
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("uart_tx_arbiter: N must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] gidx;       // owner index, meaningful only in XFER
  logic [IW-1:0] gidx_inc;   // (gidx + 1) mod N
  logic [IW-1:0] ptr;        // first index searched by the next arbitration
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          g_vld;
  logic          g_last;
  logic [7:0]    g_dat;
  logic          accept;
  logic          msg_end;
  logic          timeout_hit;
  logic          rel;

  // Modular add for index values that are always below N.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Round-robin search starting at ptr. The found flag keeps the first hit.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_vld && reqValid[wrap_add(ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(ptr, k);
      end
    end
  end

  // Owner-side mux. Each branch uses a constant index, so no wide shifters are built.
  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_dat  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (gidx == IW'(i)) begin
        g_vld  = reqValid[i];
        g_last = reqLast[i];
        g_dat  = reqData[8*i +: 8];
      end
    end
  end

  assign gidx_inc = wrap_add(gidx, 1);
  assign accept   = (state == XFER) && g_vld && !fifoFull;
  assign msg_end  = accept && g_last;
  assign rel      = msg_end || timeout_hit;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = XFER;
      XFER:    if (rel)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Everything is qualified by XFER, so the async reset clears the outputs at once.
  always_comb begin
    grant    = '0;
    reqReady = '0;
    fifoWrEn = 1'b0;
    fifoDin  = 8'h00;
    busy     = 1'b0;
    if (state == XFER) begin
      grant[gidx]    = 1'b1;
      reqReady[gidx] = !fifoFull;
      fifoWrEn       = g_vld && !fifoFull;
      fifoDin        = g_dat;
      busy           = 1'b1;
    end
  end

  // Owner index and round-robin pointer. The pointer moves past the owner on any release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gidx <= '0;
      ptr  <= '0;
    end else begin
      if (state == IDLE && pick_vld) gidx <= pick_idx;
      if (rel)                       ptr  <= gidx_inc;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic [7:0]    abort_q;
  logic          idle_tick;

  // An idle cycle is one where the owner has no byte. Cycles stalled by a full FIFO are not counted.
  assign idle_tick   = (state == XFER) && !g_vld && !fifoFull;
  // The release happens on the edge where the count would reach TIMEOUT.
  assign timeout_hit = idle_tick && (idle_cnt == CW'(TIMEOUT - 1));
  assign abortCount  = abort_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != XFER || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else if (idle_tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_q <= 8'h00;
    end else if (timeout_hit && abort_q != 8'hFF) begin
      abort_q <= abort_q + 8'h01;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abortCount  = 8'h00;
`endif

  // The FIFO must never be written while it is full, and there is at most one owner.
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst) !(fifoWrEn && fifoFull));
  a_grant_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N = 4, TIMEOUT = 8): table vectors, hand-written corner sequences,
// and random message traffic checked against a message-level round-robin reference.
// Timeout cases are compiled according to UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqLast;
  logic [3:0]  reqReady;
  logic [3:0]  grant;
  logic        fifoWrEn;
  logic [7:0]  fifoDin;
  logic        fifoFull;
  logic        busy;
  logic [7:0]  abortCount;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .grant(grant), .fifoWrEn(fifoWrEn), .fifoDin(fifoDin),
    .fifoFull(fifoFull), .busy(busy), .abortCount(abortCount)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
    reqValid = v;
    reqLast  = l;
    reqData  = d;
    fifoFull = f;
  endtask

  // Applies reset with requests pending, checks the reset state, then releases reset between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    drive(4'b1111, 4'b1111, 32'hA5A5_A5A5, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abortCount, 0);
    chk("rst_ready", reqReady, 0);
    chk("rst_wren", fifoWrEn, 0);
    chk("rst_din", fifoDin, 0);
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic [3:0]  eg;
    logic [3:0]  er;
    logic        ew;
    logic [7:0]  ed;
    logic        eb;
  } vec_t;

  vec_t tbl[14];

  // ---------------- traffic reference ----------------
  logic [8:0] rq [N][$];    // per-requester byte queue; bit 8 marks the last byte
  logic [7:0] wlog[$];      // bytes the DUT wrote, in order
  int         gord[$];      // owners in the order the DUT granted them
  int         wr12;         // DUT writes observed in the first 12 cycles

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Requesters present the heads of their queues. The reference tracks only the owner and the next-start index.
  // Valid gaps are capped at two cycles, so a timeout never fires here.
  task automatic run_traffic(input bit rnd, input int budget, output int cyc);
    int          owner;
    int          ptr_m;
    int          nxt;
    int          miss [N];
    logic [3:0]  v, lst, eg, er;
    logic [31:0] d;
    logic        f, ew;
    logic [7:0]  ed;
    logic [3:0]  prev_g;
    owner  = -1;
    ptr_m  = 0;
    cyc    = 0;
    prev_g = 4'b0000;
    wr12   = 0;
    for (int i = 0; i < N; i++) miss[i] = 0;
    while (cyc < budget && (owner >= 0 || pending())) begin
      for (int i = 0; i < N; i++) begin
        bit on;
        on = (rq[i].size() > 0) && (!rnd || miss[i] >= 2 || $urandom_range(0, 3) != 0);
        miss[i] = on ? 0 : miss[i] + 1;
        v[i] = on;
        if (on) begin
          d[8*i +: 8] = rq[i][0][7:0];
          lst[i]      = rq[i][0][8];
        end else begin
          d[8*i +: 8] = 8'($urandom);
          lst[i]      = 1'($urandom);
        end
      end
      f = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      drive(v, lst, d, f);
      @(negedge clk);
      eg = 4'b0000;
      er = 4'b0000;
      ew = 1'b0;
      ed = 8'h00;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        er[owner] = !f;
        ew        = v[owner] && !f;
        ed        = d[8*owner +: 8];
      end
      chk("rt_grant", grant, eg);
      chk("rt_ready", reqReady, er);
      chk("rt_wren", fifoWrEn, ew);
      chk("rt_din", fifoDin, ed);
      chk("rt_busy", busy, owner >= 0);
      if (fifoWrEn === 1'b1) begin
        wlog.push_back(fifoDin);
        if (cyc < 12) wr12++;
      end
      if (prev_g == 4'b0000 && grant != 4'b0000)
        for (int i = 0; i < N; i++) if (grant[i]) gord.push_back(i);
      prev_g = grant;
      if (owner < 0) begin
        nxt = -1;
        for (int k = 0; k < N; k++) if (nxt < 0 && v[(ptr_m + k) % N]) nxt = (ptr_m + k) % N;
        owner = nxt;
      end else if (ew) begin
        void'(rq[owner].pop_front());
        if (lst[owner]) begin
          ptr_m = (owner + 1) % N;
          owner = -1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          total;
    int          len;
    int          exp_ab;
    logic [7:0]  exp_s[10];
    int          exp_o[5];

    //                v        l        d              f     eg       er       ew    ed     eb
    tbl[0]  = '{4'b0100, 4'b0000, 32'h0041_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 32'h0041_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h41, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0000, 32'h0042_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h42, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 32'h0043_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h43, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 32'h1122_3344, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{4'b1111, 4'b1000, 32'h1122_3344, 1'b1, 4'b1000, 4'b0000, 1'b0, 8'h11, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1000, 32'h1122_3344, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h11, 1'b1};
    tbl[7]  = '{4'b0010, 4'b0000, 32'h0000_AA00, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0001, 32'h0000_AA55, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'hAA, 1'b1};
    tbl[9]  = '{4'b0011, 4'b0000, 32'h0000_AA55, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'hAA, 1'b1};
    tbl[10] = '{4'b0011, 4'b0010, 32'h0000_AA55, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hAA, 1'b1};
    tbl[11] = '{4'b0001, 4'b0001, 32'h0000_0055, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{4'b0001, 4'b0001, 32'h0000_0055, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h55, 1'b1};
    tbl[13] = '{4'b0000, 4'b1111, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    exp_s = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hE0, 8'hE1};
    exp_o = '{0, 1, 2, 3, 0};

    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    do_reset();

    // Table: requester 2 sends three bytes, then the pointer at 3 picks requester 3, then stalls and the rotation continues.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("tbl%0d_ready", i), reqReady, tbl[i].er);
      chk($sformatf("tbl%0d_wren", i), fifoWrEn, tbl[i].ew);
      chk($sformatf("tbl%0d_din", i), fifoDin, tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      @(posedge clk);
      #1;
    end

    // FIFO full for five cycles in the middle of a message from requester 1.
    do_reset();
    drive(4'b0010, 4'b0000, 32'h0000_1000, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_first_wren", fifoWrEn, 1);
    chk("full_first_din", fifoDin, 8'h10);
    @(posedge clk); #1;
    drive(4'b0010, 4'b0010, 32'h0000_1100, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("full_ready", reqReady, 0);
      chk("full_wren", fifoWrEn, 0);
      chk("full_grant", grant, 4'b0010);
      @(posedge clk); #1;
    end
    drive(4'b0010, 4'b0010, 32'h0000_1100, 1'b0);
    @(negedge clk);
    chk("full_drop_wren", fifoWrEn, 1);
    chk("full_drop_din", fifoDin, 8'h11);
    chk("full_drop_ready", reqReady, 4'b0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_end_grant", grant, 0);
    chk("full_end_busy", busy, 0);
    @(posedge clk); #1;

    // All four requesters start together with 2-byte messages. Requester 0 has a second message queued.
    do_reset();
    wlog.delete();
    gord.delete();
    rq[0].push_back(9'h0A0); rq[0].push_back(9'h1A1);
    rq[1].push_back(9'h0B0); rq[1].push_back(9'h1B1);
    rq[2].push_back(9'h0C0); rq[2].push_back(9'h1C1);
    rq[3].push_back(9'h0D0); rq[3].push_back(9'h1D1);
    rq[0].push_back(9'h0E0); rq[0].push_back(9'h1E1);
    run_traffic(1'b0, 100, cyc);
    chk("rr_cycles", cyc, 15);
    chk("rr_writes_12cyc", wr12, 8);
    chk("rr_grants", gord.size(), 5);
    for (int i = 0; i < 5 && i < gord.size(); i++) chk("rr_order", gord[i], exp_o[i]);
    chk("rr_bytes", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("rr_stream", wlog[i], exp_s[i]);

    // Random messages with random valid gaps and FIFO-full stalls.
    do_reset();
    wlog.delete();
    gord.delete();
    total = 0;
    for (int i = 0; i < N; i++)
      for (int m = 0; m < 6; m++) begin
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          rq[i].push_back({b == len - 1, 8'($urandom)});
          total++;
        end
      end
    run_traffic(1'b1, 3000, cyc);
    chk("rt_drained", pending(), 0);
    chk("rt_byte_count", wlog.size(), total);
    chk("rt_abort", abortCount, 0);
    for (int i = 0; i < N; i++) rq[i].delete();

    // Asynchronous reset in the middle of a message from requester 3. The pointer returns to 0.
    do_reset();
    drive(4'b0010, 4'b0010, 32'h0000_2100, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(4'b1000, 4'b0000, 32'h3100_0000, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_pre_grant", grant, 4'b1000);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_abort", abortCount, 0);
    chk("arst_wren", fifoWrEn, 0);
    chk("arst_ready", reqReady, 0);
    drive(4'b1010, 4'b0000, 32'h3100_2200, 1'b0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_regrant", grant, 4'b0010);
    @(posedge clk); #1;

    // Requester 0 sends one byte without last and then goes quiet. Requester 1 waits the whole time.
    do_reset();
    drive(4'b0011, 4'b0000, 32'h0000_B0A0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_byte_wren", fifoWrEn, 1);
    chk("tmo_byte_din", fifoDin, 8'hA0);
    @(posedge clk); #1;
    drive(4'b0010, 4'b0000, 32'h0000_B0A0, 1'b0);
    for (int j = 0; j < TMO; j++) begin
      @(negedge clk);
      chk("tmo_hold", grant, 4'b0001);
      @(posedge clk);
    end
    @(negedge clk);
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("tmo_release_grant", grant, 0);
    chk("tmo_release_busy", busy, 0);
    chk("tmo_abort1", abortCount, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_next_grant", grant, 4'b0010);
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);   // requester 1 goes quiet after one byte and is timed out too
    wait_idle("tmo_idle");
    exp_ab = 2;
    chk("tmo_abort2", abortCount, exp_ab);

    // Keep forcing timeouts past the 8-bit limit.
    for (int t = 0; t < 256; t++) begin
      drive(4'b0001, 4'b0000, 32'h0, 1'b0);
      @(posedge clk); #1;
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      wait_idle("sat_idle");
      exp_ab = (exp_ab < 255) ? exp_ab + 1 : 255;
      chk("sat_abort", abortCount, exp_ab);
    end
    chk("sat_final", abortCount, 8'hFF);
`else
    chk("tmo_off_grant", grant, 4'b0001);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("tmo_off_held", grant, 4'b0001);
    chk("tmo_off_busy", busy, 1);
    chk("tmo_off_abort", abortCount, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
